// File: rtl/pc_fetch_sequencer_pkg.sv
// Package for the PC fetch sequencer.
// Contents:
//   seq_state_e      : sequencer states (BOOT, RUN, STALL, WAIT_RDY, FLUSH)
//   pc_sel_t         : 2-bit PC source select type
//   PC_SEL_*         : typed aliases of the core-wide `PC_IF/`PC_EX/`PC_REG encodings
//   ex_redirect_sel  : maps an EX redirect to its PC source (JALR wins over branch/JAL)
`include "constants.sv"

package pc_fetch_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_BOOT,
    ST_RUN,
    ST_STALL,
    ST_WAIT_RDY,
    ST_FLUSH
  } seq_state_e;

  typedef logic [1:0] pc_sel_t;

  // Typed views of the shared encodings; the values themselves live in constants.sv.
  localparam pc_sel_t PC_SEL_IF  = `PC_IF;
  localparam pc_sel_t PC_SEL_EX  = `PC_EX;
  localparam pc_sel_t PC_SEL_REG = `PC_REG;

  // When EX carries both a JALR and a taken branch flag, the JALR target is the real one.
  function automatic pc_sel_t ex_redirect_sel(input logic is_jalr);
    return is_jalr ? PC_SEL_REG : PC_SEL_EX;
  endfunction

endpackage

// File: rtl/pc_fetch_sequencer_if.sv
// Bundle of the sequencer's control-path signals.
// Parameter: CNT_W - width of redirect_cnt.
// Signals:
//   imem_ready, hazard_stall, ex_valid, ex_br_taken, ex_jalr : into the sequencer
//   pc_en, pc_mux, flush_if_id, flush_id_ex, fetch_valid,
//   redirect_cnt                                              : out of the sequencer
//   trap_req, trap_mux                                        : into the sequencer, only when
//                                                               PC_TRAP_EN is defined
// Modports:
//   master : the sequencer itself
//   slave  : the surrounding pipeline (hazard unit, EX resolve, imem port, PC register)
interface pc_fetch_sequencer_if
  import pc_fetch_sequencer_pkg::*;
#(
  parameter int CNT_W = 16
);

  logic             imem_ready;
  logic             hazard_stall;
  logic             ex_valid;
  logic             ex_br_taken;
  logic             ex_jalr;
`ifdef PC_TRAP_EN
  logic             trap_req;
  pc_sel_t          trap_mux;
`endif
  logic             pc_en;
  pc_sel_t          pc_mux;
  logic             flush_if_id;
  logic             flush_id_ex;
  logic             fetch_valid;
  logic [CNT_W-1:0] redirect_cnt;

`ifdef PC_TRAP_EN
  modport master (
    input  imem_ready, hazard_stall, ex_valid, ex_br_taken, ex_jalr, trap_req, trap_mux,
    output pc_en, pc_mux, flush_if_id, flush_id_ex, fetch_valid, redirect_cnt
  );
  modport slave (
    output imem_ready, hazard_stall, ex_valid, ex_br_taken, ex_jalr, trap_req, trap_mux,
    input  pc_en, pc_mux, flush_if_id, flush_id_ex, fetch_valid, redirect_cnt
  );
`else
  modport master (
    input  imem_ready, hazard_stall, ex_valid, ex_br_taken, ex_jalr,
    output pc_en, pc_mux, flush_if_id, flush_id_ex, fetch_valid, redirect_cnt
  );
  modport slave (
    output imem_ready, hazard_stall, ex_valid, ex_br_taken, ex_jalr,
    input  pc_en, pc_mux, flush_if_id, flush_id_ex, fetch_valid, redirect_cnt
  );
`endif

endinterface

// File: rtl/constants.sv
// Shared PC source-select encodings used across the core.
//   `PC_IF  : sequential fetch (PC + 4)
//   `PC_EX  : EX-relative target (taken branch / JAL)
//   `PC_REG : register-relative target (JALR)
// Include-guarded so several files can pull it in safely.
`ifndef PC_CONSTANTS_SV
`define PC_CONSTANTS_SV

`define PC_IF  2'd0
`define PC_EX  2'd1
`define PC_REG 2'd2

`endif

// File: rtl/pc_flush_timer.sv
// Down-counter that times the post-redirect flush window.
// Parameter: FLUSH_CYCLES - length of the window in cycles (>= 1).
// Ports:
//   clk   in  : clock
//   rst_n in  : asynchronous active-low reset
//   load  in  : start a new window (takes priority over counting)
//   done  out : high in the last cycle of the window, and whenever idle
module pc_flush_timer #(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic done
);

  // Holds FLUSH_CYCLES-1 down to 0, so the window is exactly FLUSH_CYCLES cycles long.
  localparam int unsigned W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign done = (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = W'(FLUSH_CYCLES - 1);
    end else if (!done) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// PC fetch sequencer: decides each cycle whether the PC register loads and from which source,
// arbitrating sequential fetch, EX-stage redirects (branch/JAL -> `PC_EX, JALR -> `PC_REG),
// hazard stalls and the post-redirect pipeline flush. A redirect that arrives while imem is
// not ready is held (WAIT_RDY) and applied on the first ready cycle.
// Parameters: BOOT_CYCLES (>=1), FLUSH_CYCLES (>=1), CNT_W (redirect counter width).
// Ports:
//   clk   in : clock, rising edge
//   rst_n in : asynchronous active-low reset
//   bus       : pc_fetch_sequencer_if.master - handshake inputs and PC control outputs
// Optional feature: define PC_TRAP_EN to add trap_req/trap_mux, a top-priority redirect
// source active in every state except BOOT.
module pc_fetch_sequencer
  import pc_fetch_sequencer_pkg::*;
#(
  parameter int unsigned BOOT_CYCLES  = 1,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pc_fetch_sequencer_if.master  bus
);

  localparam int unsigned BOOT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;

  seq_state_e        state_q,    state_d;
  logic [BOOT_W-1:0] boot_cnt_q, boot_cnt_d;
  pc_sel_t           pend_mux_q, pend_mux_d;
  logic [CNT_W-1:0]  cnt_q,      cnt_d;

  logic    redir_req;
  pc_sel_t redir_mux;
  logic    flush_load;
  logic    flush_done;
  logic    pc_en;
  pc_sel_t pc_mux;
  logic    flush;

  pc_flush_timer #(
    .FLUSH_CYCLES (FLUSH_CYCLES)
  ) u_flush_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (flush_load),
    .done  (flush_done)
  );

  // Redirect source for this cycle. EX is only listened to outside BOOT and FLUSH: during
  // FLUSH the EX slot holds a killed wrong-path instruction.
  always_comb begin
    redir_req = 1'b0;
    redir_mux = PC_SEL_IF;
    if ((state_q == ST_RUN || state_q == ST_STALL || state_q == ST_WAIT_RDY) &&
        bus.ex_valid && (bus.ex_jalr || bus.ex_br_taken)) begin
      redir_req = 1'b1;
      redir_mux = ex_redirect_sel(bus.ex_jalr);
    end
`ifdef PC_TRAP_EN
    if (state_q != ST_BOOT && bus.trap_req) begin
      redir_req = 1'b1;
      redir_mux = bus.trap_mux;
    end
`endif
  end

  // Next state and the same-cycle PC controls. A fresh redirect always outranks a pending
  // one, so a new request in WAIT_RDY simply overwrites pend_mux.
  always_comb begin
    state_d    = state_q;
    boot_cnt_d = boot_cnt_q;
    pend_mux_d = pend_mux_q;
    flush_load = 1'b0;
    pc_en      = 1'b0;
    pc_mux     = PC_SEL_IF;
    flush      = 1'b0;

    if (redir_req) begin
      flush = 1'b1;
      if (bus.imem_ready) begin
        pc_en      = 1'b1;
        pc_mux     = redir_mux;
        pend_mux_d = PC_SEL_IF;
        flush_load = 1'b1;
        state_d    = ST_FLUSH;
      end else begin
        pend_mux_d = redir_mux;
        state_d    = ST_WAIT_RDY;
      end
    end else begin
      case (state_q)
        ST_BOOT: begin
          if (boot_cnt_q == '0) begin
            state_d = ST_RUN;
          end else begin
            boot_cnt_d = boot_cnt_q - 1'b1;
          end
        end
        ST_RUN, ST_STALL: begin
          // A stall keeps the PC so the same address is fetched again.
          if (bus.hazard_stall) begin
            state_d = ST_STALL;
          end else begin
            pc_en   = bus.imem_ready;
            state_d = ST_RUN;
          end
        end
        ST_WAIT_RDY: begin
          flush = 1'b1;
          if (bus.imem_ready) begin
            pc_en      = 1'b1;
            pc_mux     = pend_mux_q;
            pend_mux_d = PC_SEL_IF;
            flush_load = 1'b1;
            state_d    = ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          flush = 1'b1;
          pc_en = bus.imem_ready;
          if (flush_done) begin
            state_d = ST_RUN;
          end
        end
        default: begin
          state_d = ST_BOOT;
        end
      endcase
    end
  end

  // Counts applied redirects only; sticks at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (pc_en && (pc_mux != PC_SEL_IF) && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_BOOT;
      boot_cnt_q <= BOOT_W'(BOOT_CYCLES - 1);
      pend_mux_q <= PC_SEL_IF;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      boot_cnt_q <= boot_cnt_d;
      pend_mux_q <= pend_mux_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.pc_en        = pc_en;
  assign bus.pc_mux       = pc_mux;
  assign bus.flush_if_id  = flush;
  assign bus.flush_id_ex  = flush;
  assign bus.fetch_valid  = (state_q != ST_BOOT);
  assign bus.redirect_cnt = cnt_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Self-checking bench for pc_fetch_sequencer: directed scenarios followed by randomized
// traffic, all compared cycle by cycle against a countdown-style reference model.
// A narrow redirect counter is used so its saturation point is reached.
module tb_pc_fetch_sequencer;
  import pc_fetch_sequencer_pkg::*;

  localparam int BOOT_CYCLES  = 1;
  localparam int FLUSH_CYCLES = 2;
  localparam int CNT_W        = 4;
  localparam int CNT_MAX      = (1 << CNT_W) - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  pc_fetch_sequencer_if #(.CNT_W(CNT_W)) bus ();

  pc_fetch_sequencer #(
    .BOOT_CYCLES  (BOOT_CYCLES),
    .FLUSH_CYCLES (FLUSH_CYCLES),
    .CNT_W        (CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: remaining boot cycles, remaining flush cycles, held redirect, count.
  int      m_boot;
  int      m_flush;
  int      m_cnt;
  bit      m_pend;
  pc_sel_t m_pmux;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_boot  = BOOT_CYCLES;
    m_flush = 0;
    m_cnt   = 0;
    m_pend  = 1'b0;
    m_pmux  = PC_SEL_IF;
  endtask

  task automatic drive(input logic rdy, input logic haz, input logic v,
                       input logic br, input logic jr);
    bus.imem_ready   = rdy;
    bus.hazard_stall = haz;
    bus.ex_valid     = v;
    bus.ex_br_taken  = br;
    bus.ex_jalr      = jr;
`ifdef PC_TRAP_EN
    bus.trap_req     = 1'b0;
    bus.trap_mux     = PC_SEL_IF;
`endif
  endtask

  // Asserts reset mid-cycle, checks that every output drops at once, then releases
  // just after a rising edge so the following cycle is the first boot cycle.
  task automatic do_reset();
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_pc_en",    bus.pc_en,        0);
    check("rst_pc_mux",   bus.pc_mux,       PC_SEL_IF);
    check("rst_flush_if", bus.flush_if_id,  0);
    check("rst_flush_ex", bus.flush_id_ex,  0);
    check("rst_fetch_v",  bus.fetch_valid,  0);
    check("rst_cnt",      bus.redirect_cnt, 0);
    $display("cyc %0d reset asserted", cyc);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  // One cycle: drive inputs after the rising edge, check on the falling edge, then
  // advance the model across the next rising edge.
  task automatic step(input logic rdy, input logic haz, input logic v,
                      input logic br, input logic jr);
    logic    r;
    logic    e_en;
    logic    e_fl;
    logic    e_fv;
    bit      apply;
    pc_sel_t rmux;
    pc_sel_t e_mux;
    #1;
    drive(rdy, haz, v, br, jr);
    @(negedge clk);

    r     = v & (br | jr);
    rmux  = jr ? PC_SEL_REG : PC_SEL_EX;
    e_en  = 1'b0;
    e_mux = PC_SEL_IF;
    e_fl  = 1'b0;
    e_fv  = 1'b1;
    apply = 1'b0;

    if (m_boot > 0) begin
      e_fv = 1'b0;
    end else if (m_flush > 0) begin
      e_fl = 1'b1;
      e_en = rdy;
    end else if (r || m_pend) begin
      e_fl = 1'b1;
      if (r) begin
        m_pend = 1'b1;
        m_pmux = rmux;
      end
      if (rdy) begin
        e_en  = 1'b1;
        e_mux = m_pmux;
        apply = 1'b1;
      end
    end else begin
      e_en = rdy & ~haz;
    end

    check("pc_en",       bus.pc_en,        e_en);
    check("pc_mux",      bus.pc_mux,       e_mux);
    check("flush_if_id", bus.flush_if_id,  e_fl);
    check("flush_id_ex", bus.flush_id_ex,  e_fl);
    check("fetch_valid", bus.fetch_valid,  e_fv);
    check("redirect_cnt", bus.redirect_cnt, m_cnt);
    $display("cyc %0d rdy=%b haz=%b v=%b br=%b jr=%b -> pc_en=%b mux=%0d flush=%b fv=%b cnt=%0d",
             cyc, rdy, haz, v, br, jr, bus.pc_en, bus.pc_mux, bus.flush_if_id,
             bus.fetch_valid, bus.redirect_cnt);

    if (m_boot > 0) begin
      m_boot--;
    end else if (m_flush > 0) begin
      m_flush--;
    end
    if (apply) begin
      m_pend  = 1'b0;
      m_flush = FLUSH_CYCLES;
      if (m_cnt < CNT_MAX) m_cnt++;
    end
    cyc++;
    @(posedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required completion before 100000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_reset();

    // Boot window then sequential fetch.
    repeat (4) step(1, 0, 0, 0, 0);

    // Taken branch with imem ready; EX/stall ignored during the flush window.
    step(1, 0, 1, 1, 0);
    step(1, 0, 1, 1, 0);
    step(1, 1, 1, 0, 1);
    step(1, 0, 0, 0, 0);

    // JALR and branch together: JALR target wins.
    step(1, 0, 1, 1, 1);
    repeat (3) step(1, 0, 0, 0, 0);

    // Redirect held while imem is busy, applied on the 4th cycle.
    step(0, 0, 1, 1, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    repeat (3) step(1, 0, 0, 0, 0);

    // A newer redirect replaces the held one.
    step(0, 0, 1, 1, 0);
    step(0, 0, 1, 0, 1);
    step(1, 0, 0, 0, 0);
    repeat (3) step(1, 0, 0, 0, 0);

    // Stall, then a redirect during the stall overrides it.
    step(1, 1, 0, 0, 0);
    step(1, 1, 1, 1, 0);
    repeat (3) step(1, 0, 0, 0, 0);

    // pc_en follows imem_ready in RUN; stall release.
    step(0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);

    // Reset while waiting on imem: the held redirect must be forgotten.
    step(0, 0, 1, 1, 0);
    step(0, 0, 0, 0, 0);
    #1 drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    do_reset();
    repeat (4) step(1, 0, 0, 0, 0);

    // Randomized traffic with occasional resets; enough redirects to saturate the counter.
    for (int blk = 0; blk < 3; blk++) begin
      for (int i = 0; i < 200; i++) begin
        step($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0, $urandom_range(0, 4) < 3,
             $urandom_range(0, 3) == 0, $urandom_range(0, 6) == 0);
      end
      do_reset();
    end
    repeat (3) step(1, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
